// File: rtl/wb_skid_buffer_pkg.sv
// Shared write-back types: data/register widths, the buffered entry layout and
// the helper that turns an incoming EX/MEM bundle into a stored entry.
package pipe_pkg;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   localparam logic [RW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic          valid;
      logic          we;
      logic [RW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;

   // Only the selected word is kept; writes to r0 are dropped here but the
   // bundle still occupies a slot so ordering and occupancy stay exact.
   function automatic wb_entry_t make_entry(
      input logic [DW-1:0] alu_res,
      input logic [DW-1:0] mem_data,
      input logic [RW-1:0] aw,
      input logic          regwrite,
      input logic          memtoreg
   );
      wb_entry_t e;
      e.valid = 1'b1;
      e.we    = regwrite && (aw != REG_ZERO);
      e.addr  = aw;
      e.data  = memtoreg ? mem_data : alu_res;
      return e;
   endfunction

endpackage

// File: rtl/wb_skid_buffer_if.sv
// Handshake and register-file write bus of the write-back skid buffer.
// slave is the buffer side, master is the upstream/register-file side.
interface wb_skid_buffer_if;
   import pipe_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] mem_data;
   logic [RW-1:0] in_AW;
   logic          in_regwrite;
   logic          in_memtoreg;
   logic          flush;
   logic          wb_stall;
   logic          wr_en;
   logic [RW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    occupancy;

   modport slave (
      input  in_valid, alu_res, mem_data, in_AW, in_regwrite, in_memtoreg,
             flush, wb_stall,
      output in_ready, wr_en, wr_addr, wr_data, occupancy
   );

   modport master (
      output in_valid, alu_res, mem_data, in_AW, in_regwrite, in_memtoreg,
             flush, wb_stall,
      input  in_ready, wr_en, wr_addr, wr_data, occupancy
   );

endinterface

// File: rtl/wb_skid_buffer_fwd_cmp.sv
// One forwarding read port: address compare against both buffered entries,
// younger (SKID) entry wins. Outputs are zero on a miss or during flush.
module wb_fwd_cmp
   import pipe_pkg::*;
(
   input  wb_entry_t     head,
   input  wb_entry_t     skid,
   input  logic [RW-1:0] addr,
   input  logic          flush,
   output logic          hit,
   output logic [DW-1:0] data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      if (!flush) begin
         if (skid.valid && skid.we && (skid.addr == addr)) begin
            hit  = 1'b1;
            data = skid.data;
         end else if (head.valid && head.we && (head.addr == addr)) begin
            hit  = 1'b1;
            data = head.data;
         end
      end
   end

endmodule

// File: rtl/wb_skid_buffer.sv
// Write-back stage: 2-entry skid buffer feeding the register-file write port.
// Define WB_FWD_EN to add two forwarding read ports (rs/rt) over both entries.
module wb_skid_buffer
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   wb_skid_buffer_if.slave  bus
`ifdef WB_FWD_EN
   ,
   input  logic [RW-1:0]    rs_addr,
   input  logic [RW-1:0]    rt_addr,
   output logic             fwd_hit_a,
   output logic             fwd_hit_b,
   output logic [DW-1:0]    fwd_data_a,
   output logic [DW-1:0]    fwd_data_b
`endif
);

   wb_entry_t head_q;
   wb_entry_t skid_q;
   wb_entry_t in_entry;
   logic      ready_en_q;
   logic      in_ready;
   logic      accept;
   logic      fire;

   // ready_en_q keeps in_ready low for the first cycle out of reset
   always_comb begin
      in_ready = ready_en_q && !skid_q.valid;
      accept   = bus.in_valid && in_ready;
      fire     = head_q.valid && !bus.wb_stall && !bus.flush;
      in_entry = make_entry(bus.alu_res, bus.mem_data, bus.in_AW,
                            bus.in_regwrite, bus.in_memtoreg);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q     <= '0;
         skid_q     <= '0;
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         if (bus.flush) begin
            head_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
         end else if (fire && accept) begin
            head_q <= in_entry;
         end else if (fire) begin
            // Emptying HEAD only clears valid so wr_addr/wr_data hold.
            if (skid_q.valid) head_q       <= skid_q;
            else              head_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
         end else if (accept) begin
            if (!head_q.valid) head_q <= in_entry;
            else               skid_q <= in_entry;
         end
      end
   end

   always_comb begin
      bus.in_ready  = in_ready;
      bus.wr_en     = fire && head_q.we;
      bus.wr_addr   = head_q.addr;
      bus.wr_data   = head_q.data;
      bus.occupancy = {1'b0, head_q.valid} + {1'b0, skid_q.valid};
   end

`ifdef WB_FWD_EN
   wb_fwd_cmp u_fwd_a (
      .head  (head_q),
      .skid  (skid_q),
      .addr  (rs_addr),
      .flush (bus.flush),
      .hit   (fwd_hit_a),
      .data  (fwd_data_a)
   );

   wb_fwd_cmp u_fwd_b (
      .head  (head_q),
      .skid  (skid_q),
      .addr  (rt_addr),
      .flush (bus.flush),
      .hit   (fwd_hit_b),
      .data  (fwd_data_b)
   );
`endif

endmodule

// File: tb/tb_wb_skid_buffer.sv
// Directed bench for wb_skid_buffer: per-cycle vector table plus streaming
// order and (with WB_FWD_EN) forwarding sequences.
module tb_wb_skid_buffer;
   import pipe_pkg::*;

   logic clk;
   logic rst_n;

   wb_skid_buffer_if bus ();

`ifdef WB_FWD_EN
   logic [RW-1:0] rs_addr;
   logic [RW-1:0] rt_addr;
   logic          fwd_hit_a;
   logic          fwd_hit_b;
   logic [DW-1:0] fwd_data_a;
   logic [DW-1:0] fwd_data_b;
`endif

   wb_skid_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave)
`ifdef WB_FWD_EN
      ,
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .fwd_hit_a  (fwd_hit_a),
      .fwd_hit_b  (fwd_hit_b),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        vld;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  aw;
      logic        rw;
      logic        m2r;
      logic        fl;
      logic        st;
      logic        e_en;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [1:0]  e_occ;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic vec_t mk(
      input logic rst, input logic vld, input logic [31:0] alu, input logic [31:0] mem,
      input logic [4:0] aw, input logic rw, input logic m2r, input logic fl, input logic st,
      input logic en, input logic [4:0] addr, input logic [31:0] data,
      input logic [1:0] occ, input logic rdy
   );
      vec_t v;
      v.rst_n = rst; v.vld = vld; v.alu = alu; v.mem = mem; v.aw = aw; v.rw = rw;
      v.m2r = m2r; v.fl = fl; v.st = st; v.e_en = en; v.e_addr = addr;
      v.e_data = data; v.e_occ = occ; v.e_rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive_idle();
      bus.in_valid    = 1'b0;
      bus.alu_res     = '0;
      bus.mem_data    = '0;
      bus.in_AW       = '0;
      bus.in_regwrite = 1'b0;
      bus.in_memtoreg = 1'b0;
      bus.flush       = 1'b0;
      bus.wb_stall    = 1'b0;
   endtask

   initial begin
      int            sent;
      int            got;
      logic [36:0]   expq[$];
      logic [36:0]   e;

      rst_n = 1'b0;
      drive_idle();
      bus.in_valid = 1'b1;
`ifdef WB_FWD_EN
      rs_addr = '0;
      rt_addr = '0;
`endif

      //            rst vld alu           mem           aw  rw m2r fl st   en addr data          occ rdy
      vecs.push_back(mk(0, 1, 32'h0000_00AA, 32'h0,        3, 1, 0, 0, 0,  0, 0,  32'h0,         0, 0));
      vecs.push_back(mk(0, 1, 32'h0000_00AA, 32'h0,        3, 1, 0, 1, 0,  0, 0,  32'h0,         0, 0));
      vecs.push_back(mk(0, 1, 32'h0000_00AA, 32'h0,        3, 1, 0, 0, 0,  0, 0,  32'h0,         0, 0));
      vecs.push_back(mk(1, 1, 32'h0000_00AA, 32'h0,        3, 1, 0, 0, 0,  0, 0,  32'h0,         0, 0));
      vecs.push_back(mk(1, 1, 32'h0000_1234, 32'h0,        5, 1, 0, 0, 0,  0, 0,  32'h0,         0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_5555, 32'hDEAD_BEEF, 6, 1, 1, 0, 0,  1, 5,  32'h0000_1234, 1, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  1, 6,  32'hDEAD_BEEF, 1, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 1,  0, 6,  32'hDEAD_BEEF, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00A1, 32'h0,        1, 1, 0, 0, 1,  0, 6,  32'hDEAD_BEEF, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00B2, 32'h0,        2, 1, 0, 0, 1,  0, 1,  32'h0000_00A1, 1, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00C3, 32'h0,        3, 1, 0, 0, 1,  0, 1,  32'h0000_00A1, 2, 0));
      vecs.push_back(mk(1, 1, 32'h0000_00C3, 32'h0,        3, 1, 0, 0, 0,  1, 1,  32'h0000_00A1, 2, 0));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  1, 2,  32'h0000_00B2, 1, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 2,  32'h0000_00B2, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_0077, 32'h0,        0, 1, 0, 0, 0,  0, 2,  32'h0000_00B2, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 0,  32'h0000_0077, 1, 1));
      vecs.push_back(mk(1, 1, 32'h0000_0099, 32'h0,        9, 0, 0, 0, 0,  0, 0,  32'h0000_0077, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 9,  32'h0000_0099, 1, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00D4, 32'h0,       10, 1, 0, 0, 1,  0, 9,  32'h0000_0099, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00E5, 32'h0,       11, 1, 0, 0, 1,  0, 10, 32'h0000_00D4, 1, 1));
      vecs.push_back(mk(1, 1, 32'h0000_00F6, 32'h0,       12, 1, 0, 1, 0,  0, 10, 32'h0000_00D4, 2, 0));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 10, 32'h0000_00D4, 0, 1));
      vecs.push_back(mk(1, 1, 32'h0000_0013, 32'h0,       13, 1, 0, 1, 0,  0, 10, 32'h0000_00D4, 0, 1));
      vecs.push_back(mk(1, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 10, 32'h0000_00D4, 0, 1));

      @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         #1;
         rst_n           = vecs[i].rst_n;
         bus.in_valid    = vecs[i].vld;
         bus.alu_res     = vecs[i].alu;
         bus.mem_data    = vecs[i].mem;
         bus.in_AW       = vecs[i].aw;
         bus.in_regwrite = vecs[i].rw;
         bus.in_memtoreg = vecs[i].m2r;
         bus.flush       = vecs[i].fl;
         bus.wb_stall    = vecs[i].st;
         #2;
         chk($sformatf("v%0d_wr_en", i),     32'(bus.wr_en),     32'(vecs[i].e_en));
         chk($sformatf("v%0d_wr_addr", i),   32'(bus.wr_addr),   32'(vecs[i].e_addr));
         chk($sformatf("v%0d_wr_data", i),   bus.wr_data,        vecs[i].e_data);
         chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
         chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_rdy));
         @(posedge clk);
      end

      // Streaming with a periodic stall: writes must come out in accept order.
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
         #1;
         bus.in_valid    = (sent < 8);
         bus.alu_res     = 32'h100 + 32'(sent);
         bus.mem_data    = 32'hFFFF_0000;
         bus.in_AW       = 5'(sent + 1);
         bus.in_regwrite = 1'b1;
         bus.in_memtoreg = 1'b0;
         bus.flush       = 1'b0;
         bus.wb_stall    = (cyc % 3 == 1);
         #2;
         if (bus.wr_en) begin
            if (expq.size() == 0) begin
               chk("stream_spurious_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               chk($sformatf("stream%0d_addr", got), 32'(bus.wr_addr), 32'(e[36:32]));
               chk($sformatf("stream%0d_data", got), bus.wr_data, e[31:0]);
               got++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back({bus.in_AW, bus.alu_res});
            sent++;
         end
         @(posedge clk);
      end
      chk("stream_write_count", 32'(got), 32'd8);

`ifdef WB_FWD_EN
      // HEAD and SKID both target r7; the younger SKID entry must win.
      #1;
      drive_idle();
      bus.wb_stall = 1'b1;
      bus.in_valid = 1'b1; bus.in_regwrite = 1'b1; bus.in_AW = 5'd7; bus.alu_res = 32'h11;
      @(posedge clk);
      #1;
      bus.alu_res = 32'h22;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rs_addr = 5'd7;
      rt_addr = 5'd0;
      #2;
      chk("fwd_hit_a",  32'(fwd_hit_a), 32'd1);
      chk("fwd_data_a", fwd_data_a,     32'h22);
      chk("fwd_hit_b",  32'(fwd_hit_b), 32'd0);
      chk("fwd_data_b", fwd_data_b,     32'h0);
      bus.flush = 1'b1;
      #1;
      chk("fwd_hit_a_flush",  32'(fwd_hit_a), 32'd0);
      chk("fwd_data_a_flush", fwd_data_a,     32'h0);
      @(posedge clk);
      #1;
      drive_idle();
`endif

      #1;
      drive_idle();
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
